// File: rtl/md_unit_ctrl.sv
// ----------------------------------------------------------------------------
// md_unit_ctrl
// Sequencer for the shared HI/LO multiply/divide resource of the 5-stage
// pipeline. One mult/multu/div/divu/msub/mthi/mtlo op is accepted per start
// from the E stage. Long ops compute their result at the start edge, park it
// in pend_hi/pend_lo, and hold busy for MUL_CYCLES or DIV_CYCLES cycles
// before committing to HI/LO. mthi/mtlo write HI/LO directly at the start edge.
//
// Ports
//   clk       in   1   pipeline clock, all state on the rising edge
//   reset     in   1   asynchronous, active-low; 0 clears all state
//   start     in   1   E-stage md instruction valid this cycle
//   md_op     in   3   0 none,1 mult,2 multu,3 div,4 divu,5 mthi,6 mtlo,7 msub
//   src_a     in   32  forwarded rs value
//   src_b     in   32  forwarded rt value
//   d_md      in   1   D-stage instruction is md-class
//   busy      out  1   1 while a mult/div is in flight
//   stall_md  out  1   stall request for the D-stage md-class instruction
//   hi        out  32  architectural HI
//   lo        out  32  architectural LO
// ----------------------------------------------------------------------------
module md_unit_ctrl #(
    parameter int MUL_CYCLES = 5,
    parameter int DIV_CYCLES = 10
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [2:0]  md_op,
    input  logic [31:0] src_a,
    input  logic [31:0] src_b,
    input  logic        d_md,
    output logic        busy,
    output logic        stall_md,
    output logic [31:0] hi,
    output logic [31:0] lo
);

    typedef enum logic {IDLE, RUN} state_t;

    localparam logic [2:0] OP_MULT  = 3'd1;
    localparam logic [2:0] OP_MULTU = 3'd2;
    localparam logic [2:0] OP_DIV   = 3'd3;
    localparam logic [2:0] OP_DIVU  = 3'd4;
    localparam logic [2:0] OP_MTHI  = 3'd5;
    localparam logic [2:0] OP_MTLO  = 3'd6;
    localparam logic [2:0] OP_MSUB  = 3'd7;

    state_t      state, state_nxt;
    logic [3:0]  cnt, cnt_nxt;
    logic [31:0] pend_hi, pend_hi_nxt;
    logic [31:0] pend_lo, pend_lo_nxt;
    logic [31:0] hi_nxt, lo_nxt;

    logic               long_op;
    logic signed [63:0] a_sx, b_sx;
    logic [63:0]        prod_s, prod_u, msub_res;
    logic [31:0]        b_safe;
    logic               div_ovf;
    logic [31:0]        sdiv_q, sdiv_r, udiv_q, udiv_r;

    // Arithmetic for every op is formed from the E-stage operands so the
    // result can be parked at the start edge. The divisor is forced non-zero
    // so the dividers never see a zero; the zero case is handled in the FSM.
    // The single signed overflow case (INT_MIN / -1) is pinned explicitly
    // rather than left to the divider's wrap behaviour.
    always_comb begin
        a_sx     = {{32{src_a[31]}}, src_a};
        b_sx     = {{32{src_b[31]}}, src_b};
        prod_s   = 64'(a_sx * b_sx);
        prod_u   = {32'd0, src_a} * {32'd0, src_b};
        msub_res = {hi, lo} - prod_s;
        b_safe   = (src_b == 32'd0) ? 32'd1 : src_b;
        div_ovf  = (src_a == 32'h8000_0000) && (src_b == 32'hFFFF_FFFF);
        sdiv_q   = 32'($signed(src_a) / $signed(b_safe));
        sdiv_r   = 32'($signed(src_a) % $signed(b_safe));
        udiv_q   = src_a / b_safe;
        udiv_r   = src_a % b_safe;
        if (div_ovf) begin
            sdiv_q = 32'h8000_0000;
            sdiv_r = 32'd0;
        end
    end

    always_comb begin
        long_op = (md_op == OP_MULT) || (md_op == OP_MULTU) || (md_op == OP_DIV) ||
                  (md_op == OP_DIVU) || (md_op == OP_MSUB);
    end

    // The start cycle is included so a back-to-back md instruction in D is
    // held before busy has had a chance to rise.
    assign busy     = (state == RUN);
    assign stall_md = d_md & (busy | (start & long_op));

    // Next-state logic. A start while RUN is ignored entirely. Divide by zero
    // parks the current HI/LO so the commit leaves them unchanged; HI/LO
    // cannot change during RUN because starts are ignored there.
    always_comb begin
        state_nxt   = state;
        cnt_nxt     = cnt;
        pend_hi_nxt = pend_hi;
        pend_lo_nxt = pend_lo;
        hi_nxt      = hi;
        lo_nxt      = lo;
        case (state)
            IDLE: begin
                if (start) begin
                    case (md_op)
                        OP_MULT, OP_MULTU, OP_MSUB: begin
                            if (md_op == OP_MULT) begin
                                {pend_hi_nxt, pend_lo_nxt} = prod_s;
                            end else if (md_op == OP_MULTU) begin
                                {pend_hi_nxt, pend_lo_nxt} = prod_u;
                            end else begin
                                {pend_hi_nxt, pend_lo_nxt} = msub_res;
                            end
                            cnt_nxt   = 4'(MUL_CYCLES - 1);
                            state_nxt = RUN;
                        end
                        OP_DIV, OP_DIVU: begin
                            if (src_b == 32'd0) begin
                                pend_hi_nxt = hi;
                                pend_lo_nxt = lo;
                            end else if (md_op == OP_DIV) begin
                                pend_hi_nxt = sdiv_r;
                                pend_lo_nxt = sdiv_q;
                            end else begin
                                pend_hi_nxt = udiv_r;
                                pend_lo_nxt = udiv_q;
                            end
                            cnt_nxt   = 4'(DIV_CYCLES - 1);
                            state_nxt = RUN;
                        end
                        OP_MTHI: hi_nxt = src_a;
                        OP_MTLO: lo_nxt = src_a;
                        default: ;
                    endcase
                end
            end
            RUN: begin
                if (cnt != 4'd0) begin
                    cnt_nxt = cnt - 4'd1;
                end else begin
                    hi_nxt    = pend_hi;
                    lo_nxt    = pend_lo;
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // State register; reset discards any in-flight op immediately.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state   <= IDLE;
            cnt     <= 4'd0;
            pend_hi <= 32'd0;
            pend_lo <= 32'd0;
            hi      <= 32'd0;
            lo      <= 32'd0;
        end else begin
            state   <= state_nxt;
            cnt     <= cnt_nxt;
            pend_hi <= pend_hi_nxt;
            pend_lo <= pend_lo_nxt;
            hi      <= hi_nxt;
            lo      <= lo_nxt;
        end
    end

endmodule
